// File: rtl/regfile_pkg.sv
// Shared defaults and index helpers for the regfile_rdport_pipe register file.
package regfile_pkg;

    localparam int DEF_WIDTH    = 64;
    localparam int DEF_DEPTH    = 32;
    localparam int DEF_RD_PORTS = 2;
    localparam int DEF_ADDR_W   = $clog2(DEF_DEPTH);

    typedef logic [DEF_ADDR_W-1:0] rf_addr_t;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int zero_reg_idx(input int depth);
        return depth - 1;
    endfunction

endpackage

// File: rtl/regfile_rdport_pipe_mux_n1.sv
// mux_n1: DEPTH:1 read-select tree built from 2:1 stages; leaves past DEPTH read as zero.
module mux_n1 #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 32,
    parameter int SEL_W = 5
) (
    input  logic [DEPTH*WIDTH-1:0] data,
    input  logic [SEL_W-1:0]       sel,
    output logic [WIDTH-1:0]       out
);

    // Level 0 holds the padded leaves; level l halves the node count using sel[l-1].
    for (genvar l = 0; l <= SEL_W; l++) begin : g_lvl
        localparam int N = 1 << (SEL_W - l);
        logic [N*WIDTH-1:0] v;
        if (l == 0) begin : g_leaf
            for (genvar j = 0; j < N; j++) begin : g_in
                if (j < DEPTH) begin : g_used
                    assign v[j*WIDTH +: WIDTH] = data[j*WIDTH +: WIDTH];
                end else begin : g_pad
                    assign v[j*WIDTH +: WIDTH] = '0;
                end
            end
        end else begin : g_mux
            for (genvar n = 0; n < N; n++) begin : g_node
                assign v[n*WIDTH +: WIDTH] = sel[l-1] ? g_lvl[l-1].v[(2*n+1)*WIDTH +: WIDTH]
                                                      : g_lvl[l-1].v[(2*n)*WIDTH +: WIDTH];
            end
        end
    end

    assign out = g_lvl[SEL_W].v;

endmodule

// File: rtl/regfile_rdport_pipe.sv
// Register file with one write port and RD_PORTS registered read ports with write-through bypass.
// Define REGFILE_ZERO_REG_EN to hard-wire register DEPTH-1 to zero.
module regfile_rdport_pipe
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int RD_PORTS = DEF_RD_PORTS,
    localparam int ADDR_W   = addr_width(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic [RD_PORTS-1:0]        rd_en,
    input  logic [RD_PORTS*ADDR_W-1:0] rd_addr,
    output logic [RD_PORTS*WIDTH-1:0]  rd_data,
    output logic [RD_PORTS-1:0]        rd_valid
);

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG_EN = 1'b1;
`else
    localparam bit ZERO_REG_EN = 1'b0;
`endif

    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ZERO_IDX  = ADDR_W'(zero_reg_idx(DEPTH));

    logic                   wr_legal;
    logic [DEPTH*WIDTH-1:0] store_flat;

    // Out-of-range and zero-register writes never reach storage or the bypass.
    assign wr_legal = wr_en && ({1'b0, wr_addr} < DEPTH_EXT) &&
                      (!ZERO_REG_EN || (wr_addr != ZERO_IDX));

    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        if (ZERO_REG_EN && (i == DEPTH - 1)) begin : g_zero
            assign store_flat[i*WIDTH +: WIDTH] = '0;
        end else begin : g_word
            logic [WIDTH-1:0] word;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    word <= '0;
                end else if (wr_legal && (wr_addr == ADDR_W'(i))) begin
                    word <= wr_data;
                end
            end
            assign store_flat[i*WIDTH +: WIDTH] = word;
        end
    end

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_port
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  stored;
        logic [WIDTH-1:0]  sel_data;
        logic [WIDTH-1:0]  data_p1;
        logic              vld_p1;

        assign addr = rd_addr[p*ADDR_W +: ADDR_W];

        mux_n1 #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .SEL_W (ADDR_W)
        ) u_mux (
            .data (store_flat),
            .sel  (addr),
            .out  (stored)
        );

        assign sel_data = (wr_legal && (wr_addr == addr)) ? wr_data : stored;

        // Output register stage: data holds while idle, valid pulses one cycle per request.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                data_p1 <= '0;
                vld_p1  <= 1'b0;
            end else begin
                vld_p1 <= rd_en[p];
                if (rd_en[p]) begin
                    data_p1 <= sel_data;
                end
            end
        end

        assign rd_data[p*WIDTH +: WIDTH] = data_p1;
        assign rd_valid[p]               = vld_p1;
    end

endmodule
